// File: rtl/car_mix_acc_pkg.sv
// -----------------------------------------------------------------------------
// car_mix_acc_pkg
// Shared definitions for the carrier mixer / integrate-and-dump path: default
// datapath widths (also used by the carrier NCO and loop filter blocks) and
// the run/idle state encoding of the integrator control.
// -----------------------------------------------------------------------------
package car_mix_acc_pkg;

  localparam int CMA_IF_WIDTH  = 8;   // signed IF sample width
  localparam int CMA_CAR_WIDTH = 8;   // signed carrier cos/sin width
  localparam int CMA_CNT_WIDTH = 16;  // dump-length counter width
  localparam int CMA_SUM_WIDTH = 32;  // accumulator / result width

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } acc_state_t;

endpackage

// File: rtl/car_mix_acc_mac.sv
// -----------------------------------------------------------------------------
// car_mix_mac
// One signed multiply-accumulate lane of the carrier mixer.
//   stage 1 : prod_p1 = data * coef (optionally negated), full precision
//   stage 2 : acc_p2 += sign-extended prod_p1; on the last product of a
//             period the final sum is presented on sum_p2 with vld_p2 and the
//             accumulator restarts from zero.
// Ports:
//   rx_clk, rx_rst      clock, asynchronous active-high reset
//   clr                 discard all partial work (no dump produced)
//   vld_p0, last_p0     sample qualifier / last sample of the period
//   data_p0, coef_p0    signed IF sample and carrier value
//   sum_p2, vld_p2      dumped period sum and its one-cycle strobe
// Build option: CAR_MIX_ACC_SAT_EN -- saturate the accumulator instead of
// wrapping; once clipped the lane holds the rail until the period's dump.
// -----------------------------------------------------------------------------
module car_mix_mac
  import car_mix_acc_pkg::*;
#(
  parameter int DATA_W = CMA_IF_WIDTH,
  parameter int COEF_W = CMA_CAR_WIDTH,
  parameter int SUM_W  = CMA_SUM_WIDTH,
  parameter bit NEGATE = 1'b0
) (
  input  logic                     rx_clk,
  input  logic                     rx_rst,
  input  logic                     clr,
  input  logic                     vld_p0,
  input  logic                     last_p0,
  input  logic signed [DATA_W-1:0] data_p0,
  input  logic signed [COEF_W-1:0] coef_p0,
  output logic signed [SUM_W-1:0]  sum_p2,
  output logic                     vld_p2
);

  localparam int PROD_W = DATA_W + COEF_W;

  logic signed [PROD_W-1:0] data_x_p0;
  logic signed [PROD_W-1:0] coef_x_p0;
  logic signed [PROD_W-1:0] prod_p0;
  logic signed [PROD_W-1:0] prod_p1;
  logic                     vld_p1;
  logic                     last_p1;
  logic signed [SUM_W-1:0]  acc_p2;
  logic signed [SUM_W-1:0]  acc_next;

  // The true product always fits PROD_W bits, and so does its negation
  // because the most negative product cannot be reached by a signed pair.
  assign data_x_p0 = PROD_W'(data_p0);
  assign coef_x_p0 = PROD_W'(coef_p0);
  assign prod_p0   = NEGATE ? -(data_x_p0 * coef_x_p0) : (data_x_p0 * coef_x_p0);

`ifdef CAR_MIX_ACC_SAT_EN
  logic signed [SUM_W:0] sum_ext_p1;
  logic                  hit_p1;
  logic                  sat_p2;

  function automatic logic signed [SUM_W-1:0] sat_limit(input logic neg);
    sat_limit = neg ? {1'b1, {(SUM_W-1){1'b0}}} : {1'b0, {(SUM_W-1){1'b1}}};
  endfunction

  always_comb begin
    sum_ext_p1 = {acc_p2[SUM_W-1], acc_p2} + (SUM_W+1)'(prod_p1);
    hit_p1     = sum_ext_p1[SUM_W] ^ sum_ext_p1[SUM_W-1];
    if (sat_p2) begin
      acc_next = acc_p2;
    end else if (hit_p1) begin
      acc_next = sat_limit(sum_ext_p1[SUM_W]);
    end else begin
      acc_next = sum_ext_p1[SUM_W-1:0];
    end
  end

  // Remember that the lane clipped so later products cannot pull it off the rail.
  always_ff @(posedge rx_clk or posedge rx_rst) begin
    if (rx_rst) begin
      sat_p2 <= 1'b0;
    end else if (clr) begin
      sat_p2 <= 1'b0;
    end else if (vld_p1) begin
      sat_p2 <= last_p1 ? 1'b0 : (sat_p2 | hit_p1);
    end
  end
`else
  assign acc_next = acc_p2 + SUM_W'(prod_p1);
`endif

  // ---- stage 1: product register ----
  always_ff @(posedge rx_clk or posedge rx_rst) begin
    if (rx_rst) begin
      prod_p1 <= '0;
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end else if (clr) begin
      prod_p1 <= '0;
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end else begin
      vld_p1  <= vld_p0;
      last_p1 <= vld_p0 & last_p0;
      if (vld_p0) begin
        prod_p1 <= prod_p0;
      end
    end
  end

  // ---- stage 2: accumulate / dump ----
  always_ff @(posedge rx_clk or posedge rx_rst) begin
    if (rx_rst) begin
      acc_p2 <= '0;
      sum_p2 <= '0;
      vld_p2 <= 1'b0;
    end else if (clr) begin
      acc_p2 <= '0;
      vld_p2 <= 1'b0;
    end else begin
      vld_p2 <= vld_p1 & last_p1;
      if (vld_p1) begin
        if (last_p1) begin
          sum_p2 <= acc_next;
          acc_p2 <= '0;
        end else begin
          acc_p2 <= acc_next;
        end
      end
    end
  end

endmodule

// File: rtl/car_mix_acc.sv
// -----------------------------------------------------------------------------
// car_mix_acc
// Carrier wipe-off and integrate-and-dump. Each valid IF sample is mixed with
// the local carrier (I = if*cos, Q = -(if*sin)) and summed over rx_dump_len
// samples; the period sums are presented with a valid/ready handshake.
// Ports:
//   rx_clk, rx_rst            clock, asynchronous active-high reset
//   rx_en                     1 = integrate, 0 = idle and discard partial sums
//   rx_dump_len               samples per period (0 behaves as 1)
//   rx_if_data, rx_if_valid   signed IF sample and its qualifier
//   rx_car_cos, rx_car_sin    signed carrier aligned with rx_if_data
//   tx_acc_i, tx_acc_q        dumped I/Q sums
//   tx_acc_valid, rx_acc_ready result handshake
//   tx_ovf                    sticky: a result was overwritten unread
// Build option: CAR_MIX_ACC_SAT_EN -- accumulators saturate instead of wrap.
// Timing: tx_acc_valid rises two edges after the edge capturing the last
// sample of a period (product, accumulate, output register).
// -----------------------------------------------------------------------------
module car_mix_acc
  import car_mix_acc_pkg::*;
#(
  parameter int IF_WIDTH  = CMA_IF_WIDTH,
  parameter int CAR_WIDTH = CMA_CAR_WIDTH,
  parameter int CNT_WIDTH = CMA_CNT_WIDTH,
  parameter int SUM_WIDTH = CMA_SUM_WIDTH
) (
  input  logic                        rx_clk,
  input  logic                        rx_rst,
  input  logic                        rx_en,
  input  logic        [CNT_WIDTH-1:0] rx_dump_len,
  input  logic signed [IF_WIDTH-1:0]  rx_if_data,
  input  logic                        rx_if_valid,
  input  logic signed [CAR_WIDTH-1:0] rx_car_cos,
  input  logic signed [CAR_WIDTH-1:0] rx_car_sin,
  input  logic                        rx_acc_ready,
  output logic signed [SUM_WIDTH-1:0] tx_acc_i,
  output logic signed [SUM_WIDTH-1:0] tx_acc_q,
  output logic                        tx_acc_valid,
  output logic                        tx_ovf
);

  if (SUM_WIDTH < IF_WIDTH + CAR_WIDTH) begin : g_width_chk
    $error("car_mix_acc: SUM_WIDTH must be at least IF_WIDTH+CAR_WIDTH");
  end

  acc_state_t                 state_q;
  acc_state_t                 state_d;
  logic       [CNT_WIDTH-1:0] cnt_q;
  logic       [CNT_WIDTH-1:0] len_q;
  logic                       clr;
  logic                       vld_p0;
  logic                       last_p0;
  logic signed [SUM_WIDTH-1:0] sum_i_p2;
  logic signed [SUM_WIDTH-1:0] sum_q_p2;
  logic                       vld_i_p2;
  logic                       vld_q_p2;
  logic                       dump_p2;

  function automatic logic [CNT_WIDTH-1:0] eff_len(input logic [CNT_WIDTH-1:0] len);
    eff_len = (len == '0) ? CNT_WIDTH'(1) : len;
  endfunction

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (rx_en)  state_d = ST_RUN;
      ST_RUN:  if (!rx_en) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Leaving RUN (rx_en low) flushes counter, products and accumulators.
  assign clr     = ~rx_en;
  assign vld_p0  = (state_q == ST_RUN) & rx_en & rx_if_valid;
  // cnt_q counts 0..len-1, so len = 2^CNT_WIDTH-1 never wraps mid-period.
  assign last_p0 = vld_p0 & (cnt_q == len_q - CNT_WIDTH'(1));

  always_ff @(posedge rx_clk or posedge rx_rst) begin
    if (rx_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      len_q   <= CNT_WIDTH'(1);
    end else begin
      state_q <= state_d;
      if (!rx_en) begin
        cnt_q <= '0;
      end else if (vld_p0) begin
        cnt_q <= last_p0 ? '0 : cnt_q + CNT_WIDTH'(1);
      end
      // Period length is sampled at RUN entry and at each period boundary.
      if (((state_q == ST_IDLE) && rx_en) || last_p0) begin
        len_q <= eff_len(rx_dump_len);
      end
    end
  end

  car_mix_mac #(
    .DATA_W (IF_WIDTH),
    .COEF_W (CAR_WIDTH),
    .SUM_W  (SUM_WIDTH),
    .NEGATE (1'b0)
  ) u_mac_i (
    .rx_clk  (rx_clk),
    .rx_rst  (rx_rst),
    .clr     (clr),
    .vld_p0  (vld_p0),
    .last_p0 (last_p0),
    .data_p0 (rx_if_data),
    .coef_p0 (rx_car_cos),
    .sum_p2  (sum_i_p2),
    .vld_p2  (vld_i_p2)
  );

  car_mix_mac #(
    .DATA_W (IF_WIDTH),
    .COEF_W (CAR_WIDTH),
    .SUM_W  (SUM_WIDTH),
    .NEGATE (1'b1)
  ) u_mac_q (
    .rx_clk  (rx_clk),
    .rx_rst  (rx_rst),
    .clr     (clr),
    .vld_p0  (vld_p0),
    .last_p0 (last_p0),
    .data_p0 (rx_if_data),
    .coef_p0 (rx_car_sin),
    .sum_p2  (sum_q_p2),
    .vld_p2  (vld_q_p2)
  );

  assign dump_p2 = vld_i_p2 & vld_q_p2;

  // ---- stage 3: result register and handshake ----
  always_ff @(posedge rx_clk or posedge rx_rst) begin
    if (rx_rst) begin
      tx_acc_i     <= '0;
      tx_acc_q     <= '0;
      tx_acc_valid <= 1'b0;
      tx_ovf       <= 1'b0;
    end else if (dump_p2) begin
      tx_acc_i     <= sum_i_p2;
      tx_acc_q     <= sum_q_p2;
      tx_acc_valid <= 1'b1;
      // Overwriting an unread result is sticky; a same-edge accept is not a loss.
      if (tx_acc_valid && !rx_acc_ready) begin
        tx_ovf <= 1'b1;
      end
    end else if (tx_acc_valid && rx_acc_ready) begin
      tx_acc_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_car_mix_acc.sv
`timescale 1ns/1ps
module tb_car_mix_acc;

  localparam int IFW = 8;
  localparam int CW  = 8;
  localparam int NW  = 16;
  localparam int SW  = 24;
  localparam longint SMAX = (longint'(1) <<< (SW-1)) - 1;
  localparam longint SMIN = -(longint'(1) <<< (SW-1));
`ifdef CAR_MIX_ACC_SAT_EN
  localparam longint EXP36 = 8388607;
`else
  localparam longint EXP36 = 0;
`endif

  logic                  rx_clk = 1'b0;
  logic                  rx_rst = 1'b1;
  logic                  rx_en = 1'b0;
  logic        [NW-1:0]  rx_dump_len = '0;
  logic signed [IFW-1:0] rx_if_data = '0;
  logic                  rx_if_valid = 1'b0;
  logic signed [CW-1:0]  rx_car_cos = '0;
  logic signed [CW-1:0]  rx_car_sin = '0;
  logic                  rx_acc_ready = 1'b0;
  logic signed [SW-1:0]  tx_acc_i;
  logic signed [SW-1:0]  tx_acc_q;
  logic                  tx_acc_valid;
  logic                  tx_ovf;

  car_mix_acc #(
    .IF_WIDTH  (IFW),
    .CAR_WIDTH (CW),
    .CNT_WIDTH (NW),
    .SUM_WIDTH (SW)
  ) dut (
    .rx_clk       (rx_clk),
    .rx_rst       (rx_rst),
    .rx_en        (rx_en),
    .rx_dump_len  (rx_dump_len),
    .rx_if_data   (rx_if_data),
    .rx_if_valid  (rx_if_valid),
    .rx_car_cos   (rx_car_cos),
    .rx_car_sin   (rx_car_sin),
    .rx_acc_ready (rx_acc_ready),
    .tx_acc_i     (tx_acc_i),
    .tx_acc_q     (tx_acc_q),
    .tx_acc_valid (tx_acc_valid),
    .tx_ovf       (tx_ovf)
  );

  always #5 rx_clk = ~rx_clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit done    = 1'b0;

  // Behavioural model: per-period sums and a list of results due at a cycle.
  typedef struct { int due; longint vi; longint vq; } dump_t;
  dump_t  pend[$];
  int     cyc = 0;
  longint m_cnt = 0;
  longint m_len = 1;
  bit     was_en = 1'b0;
  longint acc[2] = '{0, 0};
  bit     sat[2] = '{1'b0, 1'b0};
  bit     exp_valid = 1'b0;
  bit     exp_ovf = 1'b0;
  longint exp_i = 0;
  longint exp_q = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint wrap_sum(input longint x);
    longint m;
    m = x & ((longint'(1) <<< SW) - 1);
    if (m > SMAX) m = m - (longint'(1) <<< SW);
    return m;
  endfunction

  function automatic longint eff_len(input logic [NW-1:0] l);
    return (l == 0) ? 1 : longint'(l);
  endfunction

  task automatic model_step();
    dump_t  d;
    longint p[2];
    longint s;
    if (rx_rst) begin
      pend.delete();
      m_cnt = 0; m_len = 1; was_en = 1'b0;
      acc = '{0, 0}; sat = '{1'b0, 1'b0};
      exp_valid = 1'b0; exp_ovf = 1'b0; exp_i = 0; exp_q = 0;
    end else begin
      cyc++;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        d = pend.pop_front();
        if (exp_valid && !rx_acc_ready) exp_ovf = 1'b1;
        exp_valid = 1'b1; exp_i = d.vi; exp_q = d.vq;
      end else if (exp_valid && rx_acc_ready) begin
        exp_valid = 1'b0;
      end
      if (!rx_en) begin
        pend.delete();
        m_cnt = 0; acc = '{0, 0}; sat = '{1'b0, 1'b0}; was_en = 1'b0;
      end else begin
        if (!was_en) begin
          m_len = eff_len(rx_dump_len);
        end else if (rx_if_valid) begin
          p[0] = longint'(rx_if_data) * longint'(rx_car_cos);
          p[1] = -(longint'(rx_if_data) * longint'(rx_car_sin));
          for (int l = 0; l < 2; l++) begin
`ifdef CAR_MIX_ACC_SAT_EN
            if (!sat[l]) begin
              s = acc[l] + p[l];
              if (s > SMAX)      begin acc[l] = SMAX; sat[l] = 1'b1; end
              else if (s < SMIN) begin acc[l] = SMIN; sat[l] = 1'b1; end
              else acc[l] = s;
            end
`else
            s = acc[l] + p[l];
            acc[l] = wrap_sum(s);
`endif
          end
          m_cnt++;
          if (m_cnt == m_len) begin
            pend.push_back('{cyc + 2, acc[0], acc[1]});
            acc = '{0, 0}; sat = '{1'b0, 1'b0}; m_cnt = 0;
            m_len = eff_len(rx_dump_len);
          end
        end
        was_en = 1'b1;
      end
    end
  endtask

  task automatic step();
    @(posedge rx_clk);
    #2;
  endtask

  task automatic wait_valid(input string name, input int max, output int n);
    bit found;
    n = 0; found = 1'b0;
    while (n < max && !found) begin
      @(negedge rx_clk);
      n++;
      if (tx_acc_valid) found = 1'b1;
    end
    if (!found) begin
      n_tests++; n_fail++;
      $display("FAIL %s: no tx_acc_valid within %0d cycles", name, max);
    end
  endtask

  task automatic do_reset();
    step(); rx_en = 1'b0; rx_if_valid = 1'b0; rx_rst = 1'b1;
    step(); rx_rst = 1'b0;
  endtask

  initial begin
    fork
      begin : stim
        int n;
        bit pat[5];
        pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        // reset state
        @(negedge rx_clk);
        chk("rst_acc_i", tx_acc_i, 0);
        chk("rst_acc_q", tx_acc_q, 0);
        chk("rst_valid", tx_acc_valid, 0);
        chk("rst_ovf", tx_ovf, 0);
        step(); rx_rst = 1'b0;

        // len=4, constant samples, every cycle
        step();
        rx_dump_len = 4; rx_if_data = 10; rx_car_cos = 100; rx_car_sin = 0;
        rx_if_valid = 1'b1; rx_acc_ready = 1'b1; rx_en = 1'b1;
        wait_valid("len4_first", 20, n);
        chk("len4_latency", n, 8);
        chk("len4_acc_i", tx_acc_i, 4000);
        chk("len4_acc_q", tx_acc_q, 0);
        for (int k = 0; k < 3; k++) begin
          @(negedge rx_clk);
          chk("len4_gap_valid", tx_acc_valid, 0);
        end
        @(negedge rx_clk);
        chk("len4_repeat_valid", tx_acc_valid, 1);
        chk("len4_repeat_i", tx_acc_i, 4000);

        // len=3, gapped valid pattern
        step(); rx_en = 1'b0; rx_if_valid = 1'b0;
        repeat (4) step();
        rx_dump_len = 3; rx_if_data = 2; rx_car_cos = 1; rx_car_sin = 5; rx_en = 1'b1;
        for (int k = 0; k < 5; k++) begin
          step(); rx_if_valid = pat[k];
        end
        step(); rx_if_valid = 1'b0;
        wait_valid("gap_first", 10, n);
        chk("gap_latency", n, 3);
        chk("gap_acc_i", tx_acc_i, 6);
        chk("gap_acc_q", tx_acc_q, -30);

        // overwrite before acceptance
        do_reset();
        rx_dump_len = 2; rx_if_data = 1; rx_car_cos = 1; rx_car_sin = 0;
        rx_acc_ready = 1'b0; rx_en = 1'b1; rx_if_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
          step(); rx_if_valid = 1'b1; rx_if_data = (k < 2) ? 8'sd1 : 8'sd3;
        end
        step(); rx_if_valid = 1'b0;
        @(negedge rx_clk);
        chk("ovr_first_valid", tx_acc_valid, 1);
        chk("ovr_first_i", tx_acc_i, 2);
        chk("ovr_first_ovf", tx_ovf, 0);
        repeat (2) @(negedge rx_clk);
        chk("ovr_second_i", tx_acc_i, 6);
        chk("ovr_second_valid", tx_acc_valid, 1);
        chk("ovr_ovf_set", tx_ovf, 1);
        step(); rx_acc_ready = 1'b1;
        step(); rx_acc_ready = 1'b0;
        @(negedge rx_clk);
        chk("ovr_accept_valid", tx_acc_valid, 0);
        chk("ovr_ovf_sticky", tx_ovf, 1);

        // reset in the middle of a period
        do_reset();
        rx_dump_len = 8; rx_if_data = 5; rx_car_cos = 7; rx_car_sin = 3;
        rx_acc_ready = 1'b0; rx_en = 1'b1; rx_if_valid = 1'b1;
        repeat (14) @(posedge rx_clk);
        #2;
        chk("rstmid_pre_valid", tx_acc_valid, 1);
        chk("rstmid_pre_i", tx_acc_i, 280);
        rx_rst = 1'b1;
        #1;
        chk("rstmid_i", tx_acc_i, 0);
        chk("rstmid_q", tx_acc_q, 0);
        chk("rstmid_valid", tx_acc_valid, 0);
        chk("rstmid_ovf", tx_ovf, 0);
        step(); rx_rst = 1'b0; rx_acc_ready = 1'b1;
        wait_valid("rstmid_next", 20, n);
        chk("rstmid_next_latency", n, 12);
        chk("rstmid_next_i", tx_acc_i, 280);
        chk("rstmid_next_q", tx_acc_q, -120);

        // disable mid-period
        step(); rx_en = 1'b0;
        repeat (4) step();
        rx_dump_len = 8; rx_if_data = 1; rx_car_cos = 1; rx_car_sin = 0;
        rx_if_valid = 1'b1; rx_en = 1'b1;
        repeat (6) step();
        rx_en = 1'b0;
        for (int k = 0; k < 4; k++) begin
          @(negedge rx_clk);
          chk("dis_no_dump", tx_acc_valid, 0);
        end
        step(); rx_if_data = 2; rx_car_cos = 3; rx_en = 1'b1;
        wait_valid("dis_next", 20, n);
        chk("dis_next_latency", n, 12);
        chk("dis_next_i", tx_acc_i, 48);

        // long period at the accumulator limit
        step(); rx_en = 1'b0;
        repeat (3) step();
        rx_dump_len = 1024; rx_if_data = -128; rx_car_cos = -128; rx_car_sin = 0;
        rx_if_valid = 1'b1; rx_en = 1'b1;
        wait_valid("big_first", 1100, n);
        chk("big_latency", n, 1028);
        chk("big_acc_i", tx_acc_i, EXP36);
        chk("big_acc_q", tx_acc_q, 0);

        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
          step();
          rx_en        = ($urandom_range(0, 49) != 0);
          rx_if_valid  = ($urandom_range(0, 3) != 0);
          rx_acc_ready = $urandom_range(0, 1) == 1;
          rx_dump_len  = NW'($urandom_range(0, 6));
          rx_if_data   = IFW'($urandom);
          rx_car_cos   = CW'($urandom);
          rx_car_sin   = CW'($urandom);
        end
        step();
        done = 1'b1;
      end
      begin : model
        while (1) begin
          @(posedge rx_clk or posedge rx_rst);
          if (done) break;
          model_step();
        end
      end
      begin : cmp
        while (1) begin
          @(negedge rx_clk);
          if (done) break;
          chk("m_valid", tx_acc_valid, exp_valid);
          chk("m_ovf", tx_ovf, exp_ovf);
          if (exp_valid) begin
            chk("m_acc_i", tx_acc_i, exp_i);
            chk("m_acc_q", tx_acc_q, exp_q);
          end
        end
      end
    join
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/car_mix_acc.md
CAR_MIX_ACC -- requirements
Module: car_mix_acc

Interface
REQ-001 Parameter IF_WIDTH, default 8: signed IF sample width.
REQ-002 Parameter CAR_WIDTH, default 8: signed carrier cos/sin width.
REQ-003 Parameter CNT_WIDTH, default 16: dump-length counter width.
REQ-004 Parameter SUM_WIDTH, default 32: accumulator and output width; SHALL be at least IF_WIDTH+CAR_WIDTH.
REQ-005 Clocking: one clock; reset is asynchronous and active-high (rx_clk, rx_rst).
REQ-006 rx_clk  input  1  system clock; all state updates on its rising edge.
REQ-007 rx_rst  input  1  asynchronous active-high reset.
REQ-008 rx_en  input  1  1 = run integration; 0 = idle, partial sums discarded.
REQ-009 rx_dump_len  input  CNT_WIDTH  samples per integration period; 0 is treated as 1.
REQ-010 rx_if_data  input  IF_WIDTH  signed IF sample.
REQ-011 rx_if_valid  input  1  qualifies rx_if_data, rx_car_cos and rx_car_sin.
REQ-012 rx_car_cos / rx_car_sin  input  CAR_WIDTH each  signed local carrier from the carrier NCO, aligned with rx_if_data.
REQ-013 tx_acc_i / tx_acc_q  output  SUM_WIDTH each  signed dumped in-phase / quadrature sums.
REQ-014 tx_acc_valid  output  1  dump result available.
REQ-015 rx_acc_ready  input  1  consumer accepts result on a rising edge where tx_acc_valid=1.
REQ-016 tx_ovf  output  1  sticky: a result was overwritten before acceptance.

Function
REQ-017 FSM states IDLE and RUN; IDLE->RUN when rx_en=1; RUN->IDLE when rx_en=0, which clears the sample counter, accumulators and product pipeline without producing a dump.
REQ-018 On entry to RUN and after each dump, rx_dump_len SHALL be latched; a change mid-period takes effect next period.
REQ-019 Stage 1: on each cycle with rx_if_valid=1 in RUN, register p_i = if*cos and p_q = -(if*sin), full-precision signed IF_WIDTH+CAR_WIDTH bits; cycles with rx_if_valid=0 are not counted and add nothing.
REQ-020 Stage 2: accumulators add sign-extended p_i/p_q one cycle after capture; default two's-complement wrap at SUM_WIDTH.
REQ-021 When the Nth product of a period is added, acc+product SHALL load tx_acc_i/tx_acc_q and the accumulators SHALL restart from 0; no sample lost across period boundaries.
REQ-022 tx_acc_valid SHALL rise exactly 2 cycles after the rising edge capturing the Nth valid sample.
REQ-023 tx_acc_valid SHALL stay high and outputs stable until a rising edge with rx_acc_ready=1 and no new dump.
REQ-024 New dump while tx_acc_valid=1 and rx_acc_ready=0: outputs overwritten, tx_acc_valid stays 1, tx_ovf set.
REQ-025 New dump in the same cycle as acceptance: new result loaded, tx_acc_valid stays 1, tx_ovf unchanged.
REQ-026 Counter SHALL never wrap mid-period; N=2^CNT_WIDTH-1 supported.

Reset
REQ-027 rx_rst=1 SHALL immediately force: FSM IDLE, counter 0, accumulators and products 0, tx_acc_i=0, tx_acc_q=0, tx_acc_valid=0, tx_ovf=0.
REQ-028 Reset mid-integration discards the partial period; first dump after release covers exactly N fresh samples.
REQ-029 tx_ovf SHALL clear only by reset.

Configuration
REQ-030 Macro CAR_MIX_ACC_SAT_EN: when defined, accumulators SHALL saturate to +(2^(SUM_WIDTH-1)-1) / -2^(SUM_WIDTH-1) per add and stay saturated until the period's dump; when undefined, wrap per REQ-020.

Structure
REQ-031 Shared package SHALL hold default widths (IF_WIDTH, CAR_WIDTH, CNT_WIDTH, SUM_WIDTH) and FSM state encodings, reused by the carrier NCO and loop blocks.
REQ-032 One sub-module, car_mix_mac: one signed multiply-accumulate lane (stage-1 product register, stage-2 accumulator, optional saturation); instantiated twice (I, Q).

Verification
REQ-033 len=4, if=+10, cos=+100, sin=0 constant, valid every cycle, ready=1 -> tx_acc_i=4000, tx_acc_q=0, valid for one cycle 2 cycles after 4th sample, repeating every 4 cycles.
REQ-034 len=3, if=+2, cos=+1, sin=+5, valid pattern 1,0,1,0,1 -> tx_acc_i=6, tx_acc_q=-30, valid 2 cycles after 5th cycle.
REQ-035 len=2, ready=0 across two dumps (if=1,cos=1 then if=3,cos=1) -> tx_acc_i=6 after 2nd dump, tx_ovf=1; ready=1 one cycle -> valid drops.
REQ-036 SUM_WIDTH=24, len=1024, if=-128, cos=-128 -> with CAR_MIX_ACC_SAT_EN tx_acc_i=8388607; without, tx_acc_i=0.
REQ-037 len=8, rst pulse after 5 samples -> all outputs 0 at once; next dump after 8 new samples equals 8*product.
REQ-038 len=8, rx_en low after 5 samples then high -> no dump; next dump covers 8 samples after re-enable.
